// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN host-side frame sender: FSM state encodings,
// accelerator pin bit positions and the class value reported on a result timeout.
package bnn_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_STROBE = 3'd1;
  localparam state_t ST_GAP    = 3'd2;
  localparam state_t ST_WAIT   = 3'd3;
  localparam state_t ST_REPORT = 3'd4;

  // Bit positions on the accelerator's bidirectional pins
  localparam int STROBE_BIT = 0;
  localparam int SOF_BIT    = 1;
  localparam int DONE_BIT   = 0;

  localparam logic [3:0] TIMEOUT_CLASS = 4'hF;

endpackage

// File: rtl/bnn_host_sender.sv
// Streams one frame of bytes onto the accelerator pins with strobe/SOF, then waits
// for result-done and reports the class. Optional wait limit: BNN_HOST_TIMEOUT_EN.
module bnn_host_sender
  import bnn_pkg::*;
#(
  parameter int FRAME_BYTES    = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] pin_ui_in,
  output logic [7:0] pin_uio_in,
  input  logic [7:0] pin_uo_out,
  input  logic [7:0] pin_uio_out,
  output logic [3:0] res_class,
  output logic       res_valid,
  output logic       busy,
  output logic       err_timeout
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

  state_t     state;
  logic [7:0] byte_cnt;
  logic       gap_open;
  logic       accept;
  logic       done;
  logic       timeout_hit;

  assign gap_open  = (byte_cnt < LAST_IDX);
  assign s_ready   = (state == ST_IDLE) || ((state == ST_GAP) && gap_open);
  assign accept    = s_valid && s_ready;
  assign done      = pin_uio_out[DONE_BIT];
  assign res_valid = (state == ST_REPORT);
  assign busy      = (state != ST_IDLE);

  // NOTE: every output written here gets a default first, so no latch is inferred.
  always_comb begin
    pin_uio_in             = '0;
    pin_uio_in[STROBE_BIT] = (state == ST_STROBE);
    pin_uio_in[SOF_BIT]    = (state == ST_STROBE) && (byte_cnt == 8'd0);
  end

`ifdef BNN_HOST_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;

  assign timeout_hit = (state == ST_WAIT) && !done &&
                       (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if ((state == ST_GAP) && !gap_open) wait_cnt <= '0;
      else if (state == ST_WAIT)          wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Pin bits the sender never looks at
  logic unused_pins;
  assign unused_pins = ^{pin_uo_out[7:4], pin_uio_out[7:1], 1'(TIMEOUT_CYCLES)};

  // NOTE: sequential state uses non-blocking assignments; the async reset clears
  // every register so a mid-frame reset leaves the pins quiet immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      byte_cnt  <= 8'd0;
      pin_ui_in <= 8'd0;
      res_class <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pin_ui_in <= s_data;
            byte_cnt  <= 8'd0;
            state     <= ST_STROBE;
          end
        end
        ST_STROBE: state <= ST_GAP;
        ST_GAP: begin
          if (!gap_open) begin
            state <= ST_WAIT;
          end else if (accept) begin
            pin_ui_in <= s_data;
            byte_cnt  <= byte_cnt + 8'd1;
            state     <= ST_STROBE;
          end
        end
        ST_WAIT: begin
          if (done) begin
            res_class <= pin_uo_out[3:0];
            state     <= ST_REPORT;
          end else if (timeout_hit) begin
            res_class <= TIMEOUT_CLASS;
            state     <= ST_REPORT;
          end
        end
        ST_REPORT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_host_sender.sv
// Directed bench for bnn_host_sender: frame streaming, result capture, stalls,
// mid-frame reset, ignored stray done, and the wait limit when compiled in.
module tb_bnn_host_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] pin_ui_in;
  logic [7:0] pin_uio_in;
  logic [7:0] pin_uo_out;
  logic [7:0] pin_uio_out;
  logic [3:0] res_class;
  logic       res_valid;
  logic       busy;
  logic       err_timeout;

  int checks   = 0;
  int failures = 0;

  bnn_host_sender #(.FRAME_BYTES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .pin_ui_in   (pin_ui_in),
    .pin_uio_in  (pin_uio_in),
    .pin_uo_out  (pin_uo_out),
    .pin_uio_out (pin_uio_out),
    .res_class   (res_class),
    .res_valid   (res_valid),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte from a ready state; ends in GAP with s_valid still high.
  task automatic send_byte(input logic [7:0] b, input logic sof);
    s_data  = b;
    s_valid = 1'b1;
    check("s_ready_before_byte", {7'd0, s_ready}, 8'h01);
    tick();
    check("strobe_sof", pin_uio_in, sof ? 8'h03 : 8'h01);
    check("ui_data_at_strobe", pin_ui_in, b);
    tick();
    check("gap_strobes_low", pin_uio_in, 8'h00);
  endtask

  initial begin
    int n;
    logic seen;
    rst         = 1'b1;
    s_data      = 8'h00;
    s_valid     = 1'b0;
    pin_uo_out  = 8'h00;
    pin_uio_out = 8'h00;
    tick();
    tick();
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_ui", pin_ui_in, 8'h00);
    check("rst_uio", pin_uio_in, 8'h00);
    check("rst_class", {4'd0, res_class}, 8'h00);
    check("rst_valid", {7'd0, res_valid}, 8'h00);
    check("rst_err", {7'd0, err_timeout}, 8'h00);
    rst = 1'b0;

    // Full frame 0x01..0x08 with s_valid held high
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 1);
    check("last_gap_not_ready", {7'd0, s_ready}, 8'h00);
    s_valid = 1'b0;
    tick();
    check("wait_busy", {7'd0, busy}, 8'h01);
    check("wait_not_ready", {7'd0, s_ready}, 8'h00);
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | res_valid | pin_uio_in[0];
    end
    check("wait_quiet", {7'd0, seen}, 8'h00);
    pin_uo_out  = 8'h07;
    pin_uio_out = 8'h01;
    tick();
    pin_uio_out = 8'h00;
    pin_uo_out  = 8'h00;
    check("report_valid", {7'd0, res_valid}, 8'h01);
    check("report_class", {4'd0, res_class}, 8'h07);
    check("report_busy", {7'd0, busy}, 8'h01);
    tick();
    check("after_report_valid", {7'd0, res_valid}, 8'h00);
    check("after_report_busy", {7'd0, busy}, 8'h00);
    check("class_held", {4'd0, res_class}, 8'h07);

    // Stray done while idle must be ignored
    pin_uo_out  = 8'h03;
    pin_uio_out = 8'h01;
    tick();
    pin_uio_out = 8'h00;
    check("idle_done_no_valid", {7'd0, res_valid}, 8'h00);
    tick();
    check("idle_done_no_valid2", {7'd0, res_valid}, 8'h00);
    check("idle_done_class", {4'd0, res_class}, 8'h07);
    check("idle_done_busy", {7'd0, busy}, 8'h00);

    // Stall 10 cycles after byte 3
    send_byte(8'h11, 1'b1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h13, 1'b0);
    s_valid = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | (pin_uio_in != 8'h00);
    end
    check("stall_no_strobe", {7'd0, seen}, 8'h00);
    check("stall_ui_held", pin_ui_in, 8'h13);
    check("stall_busy", {7'd0, busy}, 8'h01);
    send_byte(8'h14, 1'b0);
    send_byte(8'h15, 1'b0);

    // Mid-frame reset after byte 5
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ui", pin_ui_in, 8'h00);
    check("midrst_uio", pin_uio_in, 8'h00);
    check("midrst_busy", {7'd0, busy}, 8'h00);
    check("midrst_class", {4'd0, res_class}, 8'h00);
    check("midrst_valid", {7'd0, res_valid}, 8'h00);
    tick();
    rst = 1'b0;
    send_byte(8'hA1, 1'b1);
    for (int i = 2; i <= 8; i++) send_byte(8'(8'hA0 + i), 1'b0);
    s_valid = 1'b0;
    tick();

`ifdef BNN_HOST_TIMEOUT_EN
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    check("timeout_latency", 8'(n), 8'd16);
    check("timeout_valid", {7'd0, res_valid}, 8'h01);
    check("timeout_class", {4'd0, res_class}, 8'h0F);
    check("timeout_err", {7'd0, err_timeout}, 8'h01);
    tick();
    check("timeout_idle", {7'd0, busy}, 8'h00);
    check("timeout_err_sticky", {7'd0, err_timeout}, 8'h01);
`else
    n = 0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | res_valid;
    end
    check("no_limit_valid", {7'd0, seen}, 8'h00);
    check("no_limit_busy", {7'd0, busy}, 8'h01);
    check("no_limit_err", {7'd0, err_timeout}, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bnn_host_sender.md
BNN_HOST_SENDER -- requirements
Module: bnn_host_sender

Interface
- REQ-001 Parameter FRAME_BYTES, default 8: bytes per input frame (2..255).
- REQ-002 Parameter TIMEOUT_CYCLES, default 1023: maximum cycles spent waiting for the result (only used when timeout is compiled in).
- REQ-003 clk  in  1  single clock; all logic rising-edge.
- REQ-004 rst  in  1  asynchronous, active-high reset.
- REQ-005 s_data  in  8  frame byte from the host side.
- REQ-006 s_valid  in  1  s_data valid.
- REQ-007 s_ready  out  1  byte accepted when s_valid && s_ready.
- REQ-008 pin_ui_in  out  8  data driven onto the accelerator's dedicated inputs.
- REQ-009 pin_uio_in  out  8  control: bit0 byte strobe, bit1 start-of-frame; bits 7:2 are 0.
- REQ-010 pin_uo_out  in  8  accelerator output; bits 3:0 are the class index.
- REQ-011 pin_uio_out  in  8  accelerator status; bit0 is result-done.
- REQ-012 res_class  out  4  latched class of the last frame.
- REQ-013 res_valid  out  1  one-cycle pulse when res_class updates.
- REQ-014 busy  out  1  high in any state other than IDLE.
- REQ-015 err_timeout  out  1  sticky timeout flag (0 when the feature is compiled out).

Function
- REQ-016 FSM states: IDLE, STROBE, GAP, WAIT, REPORT.
- REQ-017 IDLE: s_ready=1. On a handshake, register s_data into pin_ui_in, clear the byte counter to 0, and go to STROBE.
- REQ-018 STROBE (1 cycle): pin_uio_in[0]=1. pin_uio_in[1]=1 only if the byte counter is 0. pin_ui_in is held. Go to GAP.
- REQ-019 GAP: strobes are 0 and s_ready=1 only while byte counter < FRAME_BYTES-1. A handshake loads pin_ui_in, increments the counter, and goes to STROBE. Consecutive strobes are therefore at least 2 cycles apart.
- REQ-020 GAP with counter == FRAME_BYTES-1: s_ready=0; go to WAIT on the next cycle.
- REQ-021 WAIT: s_ready=0. When pin_uio_out[0]=1, capture pin_uo_out[3:0] into res_class and go to REPORT.
- REQ-022 REPORT (1 cycle): res_valid=1, then return to IDLE.
- REQ-023 A done pulse on pin_uio_out[0] outside WAIT is ignored.
- REQ-024 s_valid low in GAP stalls indefinitely with strobes at 0; no byte is dropped or duplicated.
- REQ-025 The byte counter is 8 bits and never wraps within a frame.

Reset
- REQ-026 rst asserted at any time, including mid-frame: immediately go to IDLE and force pin_ui_in=0, pin_uio_in=0, res_class=0, res_valid=0, err_timeout=0, counters=0, busy=0.
- REQ-027 After rst deasserts, s_ready=1 on the first clock edge; the next accepted byte starts a new frame with SOF.

Configuration
- REQ-028 Macro BNN_HOST_TIMEOUT_EN defined: a wait counter clears on entry to WAIT. If it reaches TIMEOUT_CYCLES without done, set err_timeout=1 (sticky until rst), set res_class=4'hF, pulse res_valid through REPORT, and return to IDLE.
- REQ-029 Macro undefined: WAIT has no time limit, err_timeout is tied to 0, and no wait counter is synthesised.

Structure
- REQ-030 Shared package bnn_pkg holds the FSM state enum, the strobe/SOF/done bit-index constants, and the timeout sentinel 4'hF.
- REQ-031 Single flat module; no sub-module is required.

Verification
- REQ-032 Reset, then a frame of 8 bytes 0x01..0x08 with s_valid held high -> 8 strobes 2 cycles apart, SOF only with 0x01, pin_ui_in matches each byte at its strobe.
- REQ-033 After the frame, DUT model asserts done with pin_uo_out=0x07 five cycles later -> res_class=7 and res_valid high exactly 1 cycle; busy falls the next cycle.
- REQ-034 s_valid dropped for 10 cycles after byte 3 -> no strobes during the gap; byte 4 strobes once with SOF=0.
- REQ-035 rst asserted after byte 5 -> outputs zero immediately; the next frame's first byte carries SOF=1.
- REQ-036 With BNN_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, no done -> err_timeout=1, res_class=0xF, res_valid pulse, return to IDLE.
- REQ-037 A done pulse while in IDLE -> no res_valid and res_class unchanged.
